z80_io_master: RTL and testbench
================================

Name: z80_io_master

Overview:
- Bus-initiator counterpart to the bus monitor's Z80-side I/O register file.
- Generates Z80 I/O read and write machine cycles (T1, T2, TW…, T3) on a_cpu, d_cpu, io_req_cpu, rd_cpu and wr_cpu.
- Driven by a simple command/response interface.
- Used by the bus monitor to drive I/O peripherals from the FPGA side, and as the stimulus engine for bench-testing I/O slaves.

Parameters:
- BASE_WAIT, 1: automatic wait states inserted after T2; Z80 I/O cycles have 1.
- WAIT_TIMEOUT, 255: maximum extra TW cycles while wait_cpu is held low before the cycle is aborted; range 1..255.

Ports:
- clk_cpu, input, 1: bus clock; all logic on posedge.
- reset_cpu, input, 1: asynchronous, active-low reset.
- cmd_valid, input, 1: command request.
- cmd_ready, output, 1: master idle and able to accept a command.
- cmd_write, input, 1: 1 = I/O write, 0 = I/O read.
- cmd_addr, input, 8: I/O port address.
- cmd_wdata, input, 8: write data.
- rsp_valid, output, 1: one-cycle pulse at cycle completion.
- rsp_rdata, output, 8: captured read data.
- rsp_err, output, 1: wait timeout occurred; qualified by rsp_valid.
- a_cpu, output, 8: address bus.
- d_cpu, inout, 8: data bus.
- io_req_cpu, output, 1: active-low I/O request.
- rd_cpu, output, 1: active-low read strobe.
- wr_cpu, output, 1: active-low write strobe.
- wait_cpu, input, 1: active-low wait request from the slave.

Behaviour:
- Reset (asynchronous, while reset_cpu=0) forces:
  - state IDLE;
  - io_req_cpu=1, rd_cpu=1, wr_cpu=1;
  - a_cpu=8'h00, d_cpu high-Z;
  - rsp_valid=0, rsp_rdata=8'h00, rsp_err=0;
  - cmd_ready=0 while reset is asserted.
- Reset asserted mid-cycle aborts the cycle immediately. No rsp_valid is produced for the aborted command.
- cmd_ready = (state==IDLE) & reset_cpu. It is combinational.
- A command is accepted on the posedge where cmd_valid & cmd_ready. At that edge:
  - cmd_write, cmd_addr and cmd_wdata are latched;
  - state goes to T1;
  - command inputs are ignored outside IDLE.
- All bus outputs are registered. The states and the bus levels during each are:
  - T1: a_cpu = latched addr; strobes all high; d_cpu driven with wdata if write, high-Z if read. Next: T2.
  - T2: io_req_cpu=0; rd_cpu=0 (read) or wr_cpu=0 (write); address and write data held. Next: TW; wait counter loaded with BASE_WAIT, timeout counter cleared. With BASE_WAIT=0, the T2 exit follows the TW exit rule directly.
  - TW: strobes held low. Wait counter decrements each cycle. When the counter is 0:
    - wait_cpu=1: go to T3;
    - wait_cpu=0: stay and increment the timeout counter;
    - timeout counter reaching WAIT_TIMEOUT: go to T3 with the error flag set.
  - T3: io_req_cpu, rd_cpu and wr_cpu return high; a_cpu held; d_cpu released to high-Z at the start of T3, for both read and write; rsp_valid=1 for exactly this cycle. Next: IDLE.
  - IDLE: strobes high, d_cpu high-Z, a_cpu holds the last address.
- Read capture:
  - rsp_rdata is loaded from d_cpu on the clock edge that leaves TW (or T2) for T3, while rd_cpu is still low.
  - rsp_rdata holds its value until the next successful read.
  - Writes and timed-out reads leave rsp_rdata unchanged.
- rsp_err is updated at every completion: 1 on timeout, 0 otherwise.
- Latency, accept edge to rsp_valid: 3 + BASE_WAIT + (extra wait cycles) clock cycles.
- IDLE lasts at least one cycle between commands. Back-to-back throughput is one command per 4 + BASE_WAIT cycles with no waits.
- rd_cpu and wr_cpu are never low simultaneously.
- d_cpu is never driven while rd_cpu=0.
- wait_cpu is ignored outside TW and the T2 exit.

Test Plan:
- Write: cmd_write=1, addr=8'h50, wdata=8'h5A, BASE_WAIT=1, wait_cpu=1 → io_req_cpu and wr_cpu low for exactly 2 cycles (T2, TW); d_cpu=8'h5A from T1 through TW; rsp_valid pulses 4 cycles after accept; rsp_err=0; a_cpu=8'h50 throughout.
- Read: a slave model drives 8'hC3 when io_req_cpu=0 & rd_cpu=0, addr=8'h51 → rsp_rdata=8'hC3 at the rsp_valid pulse; d_cpu never driven by the master; wr_cpu stays high.
- Slave wait: wait_cpu held low for 5 cycles from T2 → 5 extra TW cycles; strobes stay low; rsp_valid 9 cycles after accept; rsp_err=0.
- Timeout: WAIT_TIMEOUT=4, wait_cpu stuck low on a read → T3 after 4 extra TW cycles; rsp_err=1; rsp_rdata keeps its previous value (8'hC3).
- Reset mid-cycle: assert reset_cpu=0 asynchronously during TW of a write → within the same cycle, strobes go high and d_cpu goes high-Z; no rsp_valid; cmd_ready=1 on the first posedge after release.
- Back-to-back: cmd_valid held high with two queued commands → second accept exactly 1 IDLE cycle after the first T3; cmd_ready=0 during T1..T3.

Source files
------------

// File: rtl/z80_io_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : z80_io_master
// Brief    : Z80 I/O read/write machine-cycle generator (T1,T2,TW..,T3)
//            driven by a command/response interface.
// Revision : 1.0
// ============================================================================
module z80_io_master #(
    parameter int BASE_WAIT    = 1,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic       clk_cpu,
    input  logic       reset_cpu,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [7:0] a_cpu,
    inout  wire  [7:0] d_cpu,
    output logic       io_req_cpu,
    output logic       rd_cpu,
    output logic       wr_cpu,
    input  logic       wait_cpu
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4
    } state_t;

    // Counter holds the automatic wait states still to run after the current TW.
    localparam logic [7:0] c_wait_load = (BASE_WAIT > 0) ? 8'(BASE_WAIT - 1) : 8'd0;
    localparam logic [7:0] c_timeout   = 8'(WAIT_TIMEOUT);

    state_t     r_state;
    logic       r_write;
    logic [7:0] r_d_out;
    logic       r_d_oe;
    logic [7:0] r_wait_cnt;
    logic [7:0] r_tmo;

    logic       w_tmo_hit;

    assign w_tmo_hit = (r_tmo == c_timeout);
    assign cmd_ready = (r_state == ST_IDLE) & reset_cpu;
    assign d_cpu     = r_d_oe ? r_d_out : 8'hzz;

    always_ff @(posedge clk_cpu or negedge reset_cpu) begin
        if (!reset_cpu) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_d_out    <= 8'h00;
            r_d_oe     <= 1'b0;
            r_wait_cnt <= 8'h00;
            r_tmo      <= 8'h00;
            a_cpu      <= 8'h00;
            io_req_cpu <= 1'b1;
            rd_cpu     <= 1'b1;
            wr_cpu     <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 8'h00;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_write <= cmd_write;
                        a_cpu   <= cmd_addr;
                        r_d_out <= cmd_wdata;
                        r_d_oe  <= cmd_write;
                        r_state <= ST_T1;
                    end
                end
                ST_T1: begin
                    io_req_cpu <= 1'b0;
                    rd_cpu     <= r_write;
                    wr_cpu     <= ~r_write;
                    r_wait_cnt <= c_wait_load;
                    r_tmo      <= 8'h00;
                    r_state    <= ST_T2;
                end
                ST_T2, ST_TW: begin
                    if (r_state == ST_TW && r_wait_cnt != 8'h00) begin
                        r_wait_cnt <= r_wait_cnt - 8'h01;
                    end else if (r_state == ST_T2 && BASE_WAIT != 0) begin
                        r_state <= ST_TW;
                    end else if (wait_cpu || w_tmo_hit) begin
                        // Slave released wait: success wins even on the timeout cycle.
                        io_req_cpu <= 1'b1;
                        rd_cpu     <= 1'b1;
                        wr_cpu     <= 1'b1;
                        r_d_oe     <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_err    <= ~wait_cpu;
                        if (!r_write && wait_cpu) begin
                            rsp_rdata <= d_cpu;
                        end
                        r_state <= ST_T3;
                    end else begin
                        r_tmo   <= r_tmo + 8'h01;
                        r_state <= ST_TW;
                    end
                end
                ST_T3: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_z80_io_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_z80_io_master
// Brief    : Scoreboard bench for z80_io_master with a waitable I/O slave model.
// Revision : 1.0
// ============================================================================
module tb_z80_io_master;

    localparam int BASE_WAIT    = 1;
    localparam int WAIT_TIMEOUT = 4;

    logic       clk_cpu   = 1'b0;
    logic       reset_cpu = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr  = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] a_cpu;
    wire  [7:0] d_cpu;
    logic       io_req_cpu;
    logic       rd_cpu;
    logic       wr_cpu;
    wire        wait_cpu;

    z80_io_master #(
        .BASE_WAIT    (BASE_WAIT),
        .WAIT_TIMEOUT (WAIT_TIMEOUT)
    ) dut (
        .clk_cpu    (clk_cpu),
        .reset_cpu  (reset_cpu),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .a_cpu      (a_cpu),
        .d_cpu      (d_cpu),
        .io_req_cpu (io_req_cpu),
        .rd_cpu     (rd_cpu),
        .wr_cpu     (wr_cpu),
        .wait_cpu   (wait_cpu)
    );

    always #5 clk_cpu = ~clk_cpu;

    // Slave: drives data during read strobe, pulls wait low for the first
    // 'stall' TW cycles (or indefinitely when 'stuck'). Undriven bus reads FF.
    logic [7:0] slv_data = 8'h00;
    int         stall    = 0;
    logic       stuck    = 1'b0;
    int         low_cnt  = 0;

    always @(posedge clk_cpu) low_cnt <= io_req_cpu ? 0 : low_cnt + 1;
    assign wait_cpu = !((low_cnt >= 1) && (stuck || (low_cnt <= stall)));
    assign d_cpu    = (!io_req_cpu && !rd_cpu) ? slv_data : 8'hzz;

    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (d_cpu[i]);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic [7:0] lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc          = 0;
    int   acc_cyc      = 0;
    int   last_rsp_cyc = 0;

    always @(posedge clk_cpu) begin
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) acc_cyc <= cyc;
    end

    always @(negedge clk_cpu) begin
        if (!rd_cpu || !wr_cpu) check("strobe_excl", 32'(rd_cpu | wr_cpu), 1);
        if (rsp_valid) begin
            last_rsp_cyc = cyc;
            if (sb.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                check("rsp_latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
            end
        end
    end

    // Returns #1 after the accept edge (inside T1); busy = cycles not ready.
    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic do_push, input logic [7:0] exp_rd,
                        input logic exp_err, input int exp_lat, output int busy);
        exp_t e;
        logic got;
        int   n;
        if (do_push) begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            e.lat   = 8'(exp_lat);
            sb.push_back(e);
        end
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        busy      = 0;
        n         = 0;
        do begin
            @(negedge clk_cpu);
            got = cmd_ready;
            if (!got) busy++;
            @(posedge clk_cpu);
            n++;
        end while (!got && n < 50);
        #1 cmd_valid = 1'b0;
        if (!got) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk_cpu);
            n++;
        end
        if (sb.size() != 0) check("rsp_timeout", 32'(sb.size()), 0);
        @(posedge clk_cpu);
        #1;
    endtask

    initial begin
        int         busy;
        int         n;
        logic [7:0] last_rd;

        repeat (2) @(negedge clk_cpu);
        check("rst_strobes", 32'({io_req_cpu, rd_cpu, wr_cpu}), 'b111);
        check("rst_addr", 32'(a_cpu), 'h00);
        check("rst_dbus", 32'(d_cpu), 'hFF);
        check("rst_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 0);
        check("rst_ready", 32'(cmd_ready), 0);
        #2 reset_cpu = 1'b1;
        @(posedge clk_cpu);
        #1 check("rel_ready", 32'(cmd_ready), 1);

        // Plain write: T1, T2, TW, T3
        last_rd = 8'h00;
        send(1'b1, 8'h50, 8'h5A, 1'b1, last_rd, 1'b0, 3 + BASE_WAIT, busy);
        @(negedge clk_cpu);
        check("wr_t1_strobes", 32'({io_req_cpu, rd_cpu, wr_cpu}), 'b111);
        check("wr_t1_addr", 32'(a_cpu), 'h50);
        check("wr_t1_data", 32'(d_cpu), 'h5A);
        @(negedge clk_cpu);
        check("wr_t2_strobes", 32'({io_req_cpu, rd_cpu, wr_cpu}), 'b010);
        check("wr_t2_data", 32'(d_cpu), 'h5A);
        @(negedge clk_cpu);
        check("wr_tw_strobes", 32'({io_req_cpu, rd_cpu, wr_cpu}), 'b010);
        check("wr_tw_data", 32'(d_cpu), 'h5A);
        @(negedge clk_cpu);
        check("wr_t3_strobes", 32'({io_req_cpu, rd_cpu, wr_cpu}), 'b111);
        check("wr_t3_dbus", 32'(d_cpu), 'hFF);
        check("wr_t3_addr", 32'(a_cpu), 'h50);
        wait_rsp();

        // Plain read
        slv_data = 8'hC3;
        last_rd  = 8'hC3;
        send(1'b0, 8'h51, 8'h00, 1'b1, last_rd, 1'b0, 3 + BASE_WAIT, busy);
        @(negedge clk_cpu);
        check("rd_t1_dbus", 32'(d_cpu), 'hFF);
        @(negedge clk_cpu);
        check("rd_t2_strobes", 32'({io_req_cpu, rd_cpu, wr_cpu}), 'b001);
        check("rd_t2_data", 32'(d_cpu), 'hC3);
        check("rd_t2_addr", 32'(a_cpu), 'h51);
        wait_rsp();
        check("rd_hold", 32'(rsp_rdata), 'hC3);

        // Wait stuck low: abort after WAIT_TIMEOUT extra TW cycles, data kept
        stuck    = 1'b1;
        slv_data = 8'h11;
        send(1'b0, 8'h52, 8'h00, 1'b1, last_rd, 1'b1, 3 + BASE_WAIT + WAIT_TIMEOUT, busy);
        wait_rsp();
        stuck = 1'b0;
        check("to_rdata_kept", 32'(rsp_rdata), 'hC3);

        // Slave waits just below and exactly at the timeout limit succeed
        for (int s = WAIT_TIMEOUT - 1; s <= WAIT_TIMEOUT; s++) begin
            stall    = s;
            slv_data = 8'(8'hA0 + s);
            last_rd  = slv_data;
            send(1'b0, 8'(8'h60 + s), 8'h00, 1'b1, last_rd, 1'b0, 3 + BASE_WAIT + s, busy);
            wait_rsp();
        end

        // Stalled write keeps strobes low through every wait cycle
        stall = 2;
        send(1'b1, 8'h70, 8'hA5, 1'b1, last_rd, 1'b0, 3 + BASE_WAIT + 2, busy);
        n = 0;
        repeat (6) begin
            @(negedge clk_cpu);
            if (!io_req_cpu && !wr_cpu) n++;
        end
        check("stall_wr_low", 32'(n), 32'(1 + BASE_WAIT + 2));
        wait_rsp();
        stall = 0;

        // Back-to-back: cmd_valid stays high across both commands
        slv_data = 8'h3C;
        send(1'b1, 8'h80, 8'h81, 1'b1, last_rd, 1'b0, 3 + BASE_WAIT, busy);
        last_rd = 8'h3C;
        send(1'b0, 8'h81, 8'h00, 1'b1, last_rd, 1'b0, 3 + BASE_WAIT, busy);
        check("b2b_busy", 32'(busy), 32'(3 + BASE_WAIT));
        check("b2b_gap", 32'(acc_cyc - last_rsp_cyc), 1);
        wait_rsp();

        // Asynchronous reset in TW of a write aborts without a response
        stuck = 1'b1;
        send(1'b1, 8'h90, 8'hE7, 1'b0, 8'h00, 1'b0, 0, busy);
        repeat (3) @(negedge clk_cpu);
        check("abort_pre_strobes", 32'({io_req_cpu, rd_cpu, wr_cpu}), 'b010);
        #2 reset_cpu = 1'b0;
        #1;
        check("abort_strobes", 32'({io_req_cpu, rd_cpu, wr_cpu}), 'b111);
        check("abort_dbus", 32'(d_cpu), 'hFF);
        check("abort_ready", 32'(cmd_ready), 0);
        stuck = 1'b0;
        repeat (2) begin
            @(negedge clk_cpu);
            check("abort_no_rsp", 32'(rsp_valid), 0);
        end
        #2 reset_cpu = 1'b1;
        @(posedge clk_cpu);
        #1;
        check("post_rst_ready", 32'(cmd_ready), 1);
        check("post_rst_rdata", 32'(rsp_rdata), 'h00);

        slv_data = 8'h5E;
        send(1'b0, 8'h91, 8'h00, 1'b1, 8'h5E, 1'b0, 3 + BASE_WAIT, busy);
        wait_rsp();
        repeat (3) @(negedge clk_cpu);
        check("sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
`default_nettype wire
